// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice processes one bit per clock,
// subtraction via inverted B with carry-in preset to sel. Results and flags are registered together.
module bit_serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, sum_reg;
    logic [CW-1:0]    cnt_reg;
    logic             c_reg, cout_reg, ovf_reg, zero_reg;

    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] res_shift;
    logic             s_bit, c_next, last_bit, accept;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_sel[gi] = b[gi] ^ sel;
        end
    endgenerate

    assign s_bit     = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign c_next    = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));
    assign res_shift = {s_bit, res_reg[WIDTH-1:1]};
    assign last_bit  = (cnt_reg == CW'(WIDTH - 1));
    assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = last_bit ? DONE : SHIFT;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            c_reg     <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg   <= a;
                b_reg   <= b_sel;
                c_reg   <= sel;
                cnt_reg <= '0;
                res_reg <= '0;
            end else if (state_reg == SHIFT) begin
                a_reg   <= a_reg >> 1;
                b_reg   <= b_reg >> 1;
                c_reg   <= c_next;
                cnt_reg <= cnt_reg + CW'(1);
                res_reg <= res_shift;
                // c_reg here is the carry into the MSB, so overflow falls out of the final slice
                if (last_bit) begin
                    sum_reg  <= res_shift;
                    cout_reg <= c_next;
                    ovf_reg  <= c_reg ^ c_next;
                    zero_reg <= (res_shift == '0);
                end
            end
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;
    assign zero = zero_reg;
endmodule

// File: tb/tb_bit_serial_addsub.sv
// Bench for bit_serial_addsub: arithmetic reference model with per-cycle compare,
// directed literal cases, busy/back-to-back/reset scenarios and a full operand sweep.
module tb_bit_serial_addsub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf, zero;
    logic [W-1:0] sum;

    bit_serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sel(sel),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ndone = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    int           m_cnt = 0;
    logic         m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b1;
    logic [W-1:0] m_sum = '0;
    logic [W-1:0] p_a = '0, p_b = '0;
    logic         p_sel = 1'b0;

    // Returns {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        int ux, uy, sx, sy, r_u, r_s;
        logic [W-1:0] su;
        logic co, ov;
        ux  = int'(x);
        uy  = int'(y);
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        r_u = s ? (ux - uy) : (ux + uy);
        r_s = s ? (sx - sy) : (sx + sy);
        su  = r_u[W-1:0];
        co  = s ? (ux >= uy) : (r_u >= (1 << W));
        ov  = (r_s > ((1 << (W-1)) - 1)) || (r_s < -(1 << (W-1)));
        return {ov, co, su};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks acceptance and completion from the edge-level timing rules
    initial begin : model
        logic [W+1:0] r;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_done = 1'b0; m_sum = '0;
                m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b1;
            end else begin
                cyc++;
                m_done = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        r      = ref_op(p_a, p_b, p_sel);
                        m_sum  = r[W-1:0];
                        m_cout = r[W];
                        m_ovf  = r[W+1];
                        m_zero = (m_sum == '0);
                        m_done = 1'b1;
                    end
                end else if (start) begin
                    p_a = a; p_b = b; p_sel = sel;
                    m_cnt = W;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("busy", 32'(busy), 32'(m_cnt > 0));
            chk("done", 32'(done), 32'(m_done));
            chk("sum",  32'(sum),  32'(m_sum));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("ovf",  32'(ovf),  32'(m_ovf));
            chk("zero", 32'(zero), 32'(m_zero));
            if (done) begin
                ndone++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                $display("op a=%0d b=%0d sel=%0d -> sum=%0d cout=%0d ovf=%0d zero=%0d",
                         p_a, p_b, p_sel, sum, cout, ovf, zero);
            end
        end
    end

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit got;
        @(negedge clk);
        a = x; b = y; sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(got);
        chk("done_timeout", 32'(got), 32'd1);
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input logic ez);
        do_op(x, y, s);
        chk("lit_sum",  32'(sum),  32'(es));
        chk("lit_cout", 32'(cout), 32'(ec));
        chk("lit_ovf",  32'(ovf),  32'(eo));
        chk("lit_zero", 32'(zero), 32'(ez));
    endtask

    initial begin : stim
        bit got;
        int n0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(sum),  32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        directed(4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
        directed(4'd7,  4'd2, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0);
        directed(4'd2,  4'd7, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0);
        directed(4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1);
        directed(4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0);

        // Start pulse during busy must be ignored
        @(negedge clk);
        a = 4'd3; b = 4'd4; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(got);
        chk("busy_ign_timeout", 32'(got), 32'd1);
        chk("busy_ign_sum", 32'(sum), 32'd7);
        n0 = ndone;
        repeat (8) @(negedge clk);
        #1;
        chk("busy_ign_ndone", 32'(ndone), 32'(n0));

        // Back-to-back: start held through DONE
        @(negedge clk);
        a = 4'd1; b = 4'd1; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'd6; b = 4'd6; sel = 1'b1;
        wait_done(got);
        chk("b2b_first_timeout", 32'(got), 32'd1);
        chk("b2b_first_sum", 32'(sum), 32'd2);
        wait_done(got);
        start = 1'b0;
        chk("b2b_second_timeout", 32'(got), 32'd1);
        chk("b2b_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd5);
        chk("b2b_sum",  32'(sum),  32'd0);
        chk("b2b_zero", 32'(zero), 32'd1);
        chk("b2b_cout", 32'(cout), 32'd1);
        repeat (2) @(negedge clk);

        // Asynchronous reset on the second SHIFT cycle
        @(negedge clk);
        a = 4'd5; b = 4'd6; sel = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum",  32'(sum),  32'd0);
        chk("arst_zero", 32'(zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n0 = ndone;
        repeat (8) @(negedge clk);
        #1;
        chk("arst_no_done", 32'(ndone), 32'(n0));
        directed(4'd9, 4'd9, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);

        // Full sweep, each result checked by the per-cycle model compare
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < (1 << W); x++)
                for (int y = 0; y < (1 << W); y++)
                    do_op(W'(x), W'(y), s[0]);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
